// File: rtl/mm2s_axi_read_master_ob.sv
`default_nettype none
// ============================================================================
// Module   : mm2s_axi_read_master_ob
// Purpose  : AXI4 read engine for the MM2S path. It fetches len_bytes_i bytes
//            starting at src_addr_i and pushes every good beat into the MM2S
//            stream FIFO. Several bursts can be outstanding, bursts are split
//            at 4 KB boundaries, and a transfer can be aborted or drained after
//            a read error.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start_i, src_addr_i, len_bytes_i, max_beats_i, abort_i - command
//            busy_o, done_o, err_o, err_code_o - status
//                                    (00 ok, 01 rresp, 10 align/len, 11 abort)
//            fifo_full, fifo_wr_en, fifo_wr_data - stream FIFO write side
//            m_axi_ar*, m_axi_r* - AXI4 read address and read data channels
// Revision : 1.0 - initial release
// ============================================================================
module mm2s_axi_read_master_ob #(
  parameter int AW              = 32,
  parameter int DW              = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] src_addr_i,
  input  logic [31:0]   len_bytes_i,
  input  logic [7:0]    max_beats_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  input  logic          fifo_full,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  output logic [AW-1:0] m_axi_araddr,
  output logic [7:0]    m_axi_arlen,
  output logic [2:0]    m_axi_arsize,
  output logic [1:0]    m_axi_arburst,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  input  logic [DW-1:0] m_axi_rdata,
  input  logic [1:0]    m_axi_rresp,
  input  logic          m_axi_rlast,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready
);

  localparam int            BPB  = DW / 8;
  localparam int            SZ   = $clog2(BPB);
  localparam int            OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;         // next address to request
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic          arvalid_q, arvalid_d;
  logic [31:0]   iss_left_q, iss_left_d; // beats not yet requested
  logic [31:0]   rcv_left_q, rcv_left_d; // beats not yet received
  logic [OW-1:0] outst_q, outst_d;       // ARs issued without final RLAST
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic          ar_fire, r_acc, r_last_acc, r_err, misaligned;
  logic [31:0]   mb, to4k, beats, burst_beats;
  logic [AW-1:0] burst_bytes;

  assign ar_fire    = arvalid_q & m_axi_arready;
  assign r_acc      = m_axi_rvalid & m_axi_rready;
  assign r_last_acc = r_acc & m_axi_rlast;
  assign r_err      = r_acc & (m_axi_rresp != 2'b00);
  assign misaligned = ((len_bytes_i & 32'(BPB - 1)) != 32'd0) ||
                      ((src_addr_i & AW'(BPB - 1)) != '0);

  // Length of the next burst: the smallest of the programmed maximum, the
  // beats still to request and the beats left before the next 4 KB boundary.
  always_comb begin
    mb    = (max_beats_i == 8'd0) ? 32'd1 : {24'd0, max_beats_i};
    to4k  = (32'd4096 - {20'd0, addr_q[11:0]}) >> SZ;
    beats = mb;
    if (iss_left_q < beats) beats = iss_left_q;
    if (to4k < beats)       beats = to4k;
  end

  assign burst_beats = {24'd0, arlen_q} + 32'd1;
  assign burst_bytes = AW'(burst_beats << SZ);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    iss_left_d = iss_left_q;
    rcv_left_d = rcv_left_q;
    err_d      = err_q;
    code_d     = code_q;

    case ({ar_fire, r_last_acc})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d  = 1'b0;
          code_d = 2'b00;
          if (len_bytes_i == 32'd0) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_DONE;
          end else begin
            addr_d     = src_addr_i;
            iss_left_d = len_bytes_i >> SZ;
            rcv_left_d = len_bytes_i >> SZ;
            state_d    = S_RUN;
          end
        end
      end

      S_RUN: begin
        // The cycle after a handshake never issues, so ARs are at least two
        // cycles apart and the address/count updates have settled.
        if (ar_fire) begin
          arvalid_d  = 1'b0;
          addr_d     = addr_q + burst_bytes;
          iss_left_d = iss_left_q - burst_beats;
        end else if (!arvalid_q && (iss_left_q != 32'd0) && (outst_q < MAXO) &&
                     !abort_i && !r_err) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(beats - 32'd1);
        end

        if (r_acc && !r_err) rcv_left_d = rcv_left_q - 32'd1;

        // An unaccepted AR stays valid in DRAIN until its handshake, so both
        // error and abort can leave RUN immediately.
        if (r_err) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = S_DRAIN;
        end else if (abort_i) begin
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = S_DRAIN;
        end else if ((rcv_left_d == 32'd0) && (outst_d == '0)) begin
          state_d = S_DONE;
        end
      end

      S_DRAIN: begin
        if (ar_fire) arvalid_d = 1'b0;
        if (!arvalid_q && (outst_q == '0)) state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= 8'd0;
      arvalid_q  <= 1'b0;
      iss_left_q <= 32'd0;
      rcv_left_q <= 32'd0;
      outst_q    <= '0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      iss_left_q <= iss_left_d;
      rcv_left_q <= rcv_left_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  // DRAIN discards data, so the FIFO level does not matter there.
  assign m_axi_rready  = (outst_q != '0) &&
                         (((state_q == S_RUN) && !fifo_full) || (state_q == S_DRAIN));
  assign fifo_wr_en    = r_acc && (state_q == S_RUN) && (m_axi_rresp == 2'b00);
  assign fifo_wr_data  = m_axi_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mm2s_axi_read_master_ob.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mm2s_axi_read_master_ob
// Purpose  : Self-checking bench for mm2s_axi_read_master_ob (DW=64). A small
//            AXI read slave returns an address-derived data pattern; a table
//            of commands checks AR splitting, write counts and status, and
//            hand-written sequences cover outstanding limit, SLVERR, FIFO
//            back-pressure, abort and reset mid-burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm2s_axi_read_master_ob;

  logic        clk, rst, start_i, abort_i, fifo_full;
  logic [31:0] src_addr_i, len_bytes_i;
  logic [7:0]  max_beats_i;
  logic        busy_o, done_o, err_o, fifo_wr_en;
  logic [1:0]  err_code_o;
  logic [63:0] fifo_wr_data;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  mm2s_axi_read_master_ob #(.AW(32), .DW(64), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
    .len_bytes_i(len_bytes_i), .max_beats_i(max_beats_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  // ---------------- slave model and monitor ----------------
  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } ar_t;

  ar_t         arq[$];
  int          beat, served, cyc;
  bit          ar_hs, r_hs, r_hold, err_en;
  int          err_burst, err_beat;
  logic [31:0] cap_a;
  logic [7:0]  cap_l;
  int          ar_fires, wr_cnt, data_bad, proto_bad, first_rlast_cyc, fifth_cyc;
  logic [31:0] ar_a0, ar_a1, exp_wr_addr;
  logic [7:0]  ar_l0, ar_l1;

  initial begin
    beat = 0; served = 0; cyc = 0; ar_hs = 0; r_hs = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ar_hs) arq.push_back('{a: cap_a, l: cap_l});
      if (r_hs && arq.size() > 0) begin
        if (beat == int'(arq[0].l)) begin
          void'(arq.pop_front());
          beat = 0;
          served++;
        end else begin
          beat++;
        end
      end
      if (rst) begin
        arq.delete();
        beat = 0;
      end
      m_axi_arready = (cyc % 3) != 0;
      if (arq.size() > 0 && !r_hold) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = pat(arq[0].a + 32'(beat * 8));
        m_axi_rlast  = (beat == int'(arq[0].l));
        m_axi_rresp  = (err_en && served == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
      #1;
      ar_hs = m_axi_arvalid && m_axi_arready && !rst;
      r_hs  = m_axi_rvalid && m_axi_rready && !rst;
      if (ar_hs) begin
        cap_a = m_axi_araddr;
        cap_l = m_axi_arlen;
        if (ar_fires == 0) begin ar_a0 = cap_a; ar_l0 = cap_l; end
        if (ar_fires == 1) begin ar_a1 = cap_a; ar_l1 = cap_l; end
        if (m_axi_arsize != 3'd3 || m_axi_arburst != 2'b01) proto_bad++;
        if (({20'd0, cap_a[11:0]} + ((32'(cap_l) + 32'd1) << 3)) > 32'd4096) proto_bad++;
        ar_fires++;
        if (ar_fires == 5) fifth_cyc = cyc;
      end
      if (r_hs && m_axi_rlast && first_rlast_cyc < 0) first_rlast_cyc = cyc;
      if (fifo_wr_en && !rst) begin
        if (fifo_wr_data !== pat(exp_wr_addr)) data_bad++;
        exp_wr_addr = exp_wr_addr + 32'd8;
        wr_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int   lat;
  logic d_err;
  logic [1:0] d_code;

  task automatic do_cmd(input logic [31:0] a, input logic [31:0] l, input logic [7:0] m);
    @(negedge clk);
    src_addr_i = a; len_bytes_i = l; max_beats_i = m; start_i = 1'b1;
    ar_fires = 0; wr_cnt = 0; data_bad = 0; proto_bad = 0; served = 0;
    first_rlast_cyc = -1; fifth_cyc = -1; exp_wr_addr = a;
    ar_a0 = '0; ar_a1 = '0; ar_l0 = '0; ar_l1 = '0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called just after a negedge; returns cycles until done_o (or -1).
  task automatic wait_done(input int budget);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      #2;
      if (done_o) begin
        lat = i; d_err = err_o; d_code = err_code_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #2;
      if (wr_cnt >= n) break;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    logic [7:0]  maxb;
    int          n_ar;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
    int          n_wr;
    logic [1:0]  code;
    logic        err;
  } vec_t;

  vec_t vecs[8];
  int   w0, rr_bad;

  initial begin
    vecs[0] = '{32'h0000_1000, 32'd256, 8'd16,  2, 32'h0000_1000, 8'd15, 32'h0000_1080, 8'd15, 32, 2'b00, 1'b0};
    vecs[1] = '{32'h0000_0FC0, 32'd128, 8'd16,  2, 32'h0000_0FC0, 8'd7,  32'h0000_1000, 8'd7,  16, 2'b00, 1'b0};
    vecs[2] = '{32'h0000_1004, 32'd64,  8'd16,  0, 32'h0,         8'd0,  32'h0,         8'd0,  0,  2'b10, 1'b1};
    vecs[3] = '{32'h0000_2000, 32'd0,   8'd4,   0, 32'h0,         8'd0,  32'h0,         8'd0,  0,  2'b00, 1'b0};
    vecs[4] = '{32'h0000_3000, 32'd24,  8'd0,   3, 32'h0000_3000, 8'd0,  32'h0000_3008, 8'd0,  3,  2'b00, 1'b0};
    vecs[5] = '{32'h0000_0FF0, 32'd64,  8'd255, 2, 32'h0000_0FF0, 8'd1,  32'h0000_1000, 8'd5,  8,  2'b00, 1'b0};
    vecs[6] = '{32'h0000_4000, 32'd66,  8'd8,   0, 32'h0,         8'd0,  32'h0,         8'd0,  0,  2'b10, 1'b1};
    vecs[7] = '{32'hFFFF_FFF0, 32'd32,  8'd16,  2, 32'hFFFF_FFF0, 8'd1,  32'h0000_0000, 8'd1,  4,  2'b00, 1'b0};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; fifo_full = 1'b0;
    src_addr_i = '0; len_bytes_i = '0; max_beats_i = '0;
    r_hold = 1'b0; err_en = 1'b0; err_burst = 0; err_beat = 0;
    first_rlast_cyc = -1; fifth_cyc = -1; exp_wr_addr = '0;
    ar_fires = 0; wr_cnt = 0; data_bad = 0; proto_bad = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", {err_o, err_code_o}, 0);
    chk("rst_axi", {m_axi_arvalid, m_axi_rready, fifo_wr_en}, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven commands ----------------
    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].addr, vecs[i].len, vecs[i].maxb);
      wait_done(3000);
      chk($sformatf("v%0d_done", i), lat >= 0, 1);
      if (vecs[i].n_ar == 0) chk($sformatf("v%0d_lat", i), lat, 0);
      chk($sformatf("v%0d_ars", i), ar_fires, vecs[i].n_ar);
      if (vecs[i].n_ar >= 1) chk($sformatf("v%0d_ar0", i), {ar_a0, ar_l0}, {vecs[i].a0, vecs[i].l0});
      if (vecs[i].n_ar >= 2) chk($sformatf("v%0d_ar1", i), {ar_a1, ar_l1}, {vecs[i].a1, vecs[i].l1});
      chk($sformatf("v%0d_wr", i), wr_cnt, vecs[i].n_wr);
      chk($sformatf("v%0d_status", i), {d_err, d_code}, {vecs[i].err, vecs[i].code});
      chk($sformatf("v%0d_data", i), data_bad, 0);
      chk($sformatf("v%0d_proto", i), proto_bad, 0);
      @(negedge clk);
      #2;
      chk($sformatf("v%0d_idle", i), {busy_o, done_o}, 0);
      chk($sformatf("v%0d_sticky", i), err_o, vecs[i].err);
    end

    // ---------------- outstanding limit ----------------
    r_hold = 1'b1;
    do_cmd(32'h0000_8000, 32'd1024, 8'd8);
    repeat (60) @(negedge clk);
    #2;
    chk("os_ar4", ar_fires, 4);
    chk("os_busy", busy_o, 1);
    r_hold = 1'b0;
    @(negedge clk);
    wait_done(3000);
    chk("os_done", lat >= 0, 1);
    chk("os_ars", ar_fires, 16);
    chk("os_wr", wr_cnt, 128);
    chk("os_order", (first_rlast_cyc >= 0) && (fifth_cyc > first_rlast_cyc), 1);
    chk("os_data", data_bad, 0);
    chk("os_status", {d_err, d_code}, 0);

    // ---------------- SLVERR with several bursts outstanding ----------------
    r_hold = 1'b1; err_en = 1'b1; err_burst = 0; err_beat = 2;
    do_cmd(32'h0000_9000, 32'd256, 8'd8);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (ar_fires >= 3) break;
    end
    chk("se_ar3", ar_fires >= 3, 1);
    r_hold = 1'b0;
    @(negedge clk);
    wait_done(3000);
    chk("se_done", lat >= 0, 1);
    chk("se_wr", wr_cnt, 2);
    chk("se_status", {d_err, d_code}, 3'b101);
    chk("se_drained", served, ar_fires);
    chk("se_qempty", arq.size(), 0);
    chk("se_data", data_bad, 0);
    err_en = 1'b0;

    // ---------------- FIFO back-pressure ----------------
    do_cmd(32'h0000_A000, 32'd256, 8'd16);
    wait_writes(5);
    w0 = wr_cnt; rr_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fifo_full = 1'b1;
      #2;
      if (m_axi_rready) rr_bad++;
    end
    chk("ff_rready", rr_bad, 0);
    chk("ff_nowrite", wr_cnt, w0);
    chk("ff_busy", busy_o, 1);
    @(negedge clk);
    fifo_full = 1'b0;
    wait_done(3000);
    chk("ff_done", lat >= 0, 1);
    chk("ff_wr", wr_cnt, 32);
    chk("ff_data", data_bad, 0);
    chk("ff_status", {d_err, d_code}, 0);

    // ---------------- abort mid-transfer ----------------
    do_cmd(32'h0000_B000, 32'd1024, 8'd8);
    wait_writes(20);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #2;
    w0 = wr_cnt;
    wait_done(3000);
    chk("ab_done", lat >= 0, 1);
    chk("ab_status", {d_err, d_code}, 3'b111);
    chk("ab_nowrite", wr_cnt, w0);
    chk("ab_short", (wr_cnt < 128) && (ar_fires < 16), 1);
    chk("ab_drained", served, ar_fires);
    chk("ab_data", data_bad, 0);

    // ---------------- reset mid-burst ----------------
    do_cmd(32'h0000_C000, 32'd256, 8'd16);
    wait_writes(5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("rm_busy_done", {busy_o, done_o}, 0);
    chk("rm_err", {err_o, err_code_o}, 0);
    chk("rm_axi", {m_axi_arvalid, m_axi_rready, fifo_wr_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(32'h0000_D000, 32'd64, 8'd4);
    wait_done(3000);
    chk("rm_recover", {lat >= 0, d_err, d_code}, 4'b1000);
    chk("rm_wr", wr_cnt, 8);
    chk("rm_data", data_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
